// File: rtl/mips_instr_encoder.sv
// Encodes abstract instruction requests into MIPS words, queued with sequential load addresses.
// Optional build macro MIPS_ENC_LI_EN compiles in the `li` pseudo-instruction (LI_LO state).
module mips_instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_kind,
    input  logic [4:0]               in_rs,
    input  logic [4:0]               in_rt,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_shamt,
    input  logic [31:0]              in_imm,
    input  logic [25:0]              in_target,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_addr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, LI_LO} state_t;
    state_t state, state_nxt;

    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_addr  [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic [31:0]   addr_cnt;
    logic          full, push, pop, accept, legal;
    logic [31:0]   enc_word, push_word;

`ifdef MIPS_ENC_LI_EN
    logic          li_two;
    logic [4:0]    li_rt;
    logic [15:0]   li_lo;
`else
    logic          unused_imm_hi;
    assign unused_imm_hi = ^in_imm[31:16];
`endif

    assign full      = (cnt == (AW+1)'(DEPTH));
    assign out_valid = (cnt != '0);
    assign pop       = out_valid & out_ready;
    assign accept    = in_valid & in_ready;
    assign level     = cnt;
    // Empty FIFO shows the address the next word will get.
    assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
    assign out_addr  = out_valid ? mem_addr[rd_ptr]  : addr_cnt;

    always_comb begin
        enc_word = '0;
        legal    = 1'b1;
`ifdef MIPS_ENC_LI_EN
        li_two   = 1'b0;
`endif
        case (in_kind)
            4'd0: enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};
            4'd1: enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};
            4'd2: enc_word = {6'h0D, in_rs, in_rt, in_imm[15:0]};
            4'd3: enc_word = {6'h23, in_rs, in_rt, in_imm[15:0]};
            4'd4: enc_word = {6'h2B, in_rs, in_rt, in_imm[15:0]};
            4'd5: enc_word = {6'h04, in_rs, in_rt, in_imm[15:0]};
            4'd6: enc_word = {6'h0F, 5'd0, in_rt, in_imm[15:0]};
            4'd7: enc_word = {6'h03, in_target};
            4'd8: enc_word = {6'h00, in_rs, 15'd0, 6'h08};
            4'd9: enc_word = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h00};
`ifdef MIPS_ENC_LI_EN
            4'd10: begin
                if (in_imm[31:16] == 16'd0)
                    enc_word = {6'h0D, 5'd0, in_rt, in_imm[15:0]};
                else begin
                    enc_word = {6'h0F, 5'd0, in_rt, in_imm[31:16]};
                    li_two   = (in_imm[15:0] != 16'd0);
                end
            end
`endif
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
`ifdef MIPS_ENC_LI_EN
        case (state)
            IDLE:    if (accept && li_two) state_nxt = LI_LO;
            LI_LO:   if (!full) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`else
        state_nxt = IDLE;
`endif
    end

    always_comb begin
        in_ready  = 1'b0;
        push      = 1'b0;
        push_word = enc_word;
        case (state)
            IDLE: begin
                in_ready = !reset && !full;
                push     = in_valid && !reset && !full && legal;
            end
`ifdef MIPS_ENC_LI_EN
            LI_LO: begin
                push      = !full;
                push_word = {6'h0D, li_rt, li_rt, li_lo};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= push_word;
            mem_addr[wr_ptr]  <= addr_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            addr_cnt <= BASE_ADDR;
            err      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                addr_cnt <= addr_cnt + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            if (accept && !legal) err <= 1'b1;
        end
    end

`ifdef MIPS_ENC_LI_EN
    always_ff @(posedge clk) begin
        if (accept && li_two) begin
            li_rt <= in_rt;
            li_lo <= in_imm[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: directed vector table, hand sequences, and randomized
// traffic checked against a queue-based reference model.
module tb_mips_instr_encoder;
    localparam logic [31:0] BASE = 32'h0000_3000;
`ifdef MIPS_ENC_LI_EN
    localparam bit LI_EN = 1'b1;
`else
    localparam bit LI_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready, err;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [31:0] in_imm, out_instr, out_addr;
    logic [25:0] in_target;
    logic [2:0]  level;

    mips_instr_encoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .level(level), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  kind;
        logic [4:0]  rs, rt, rd, sh;
        logic [31:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] exp_q[$];
    logic [63:0] head_e;
    logic [31:0] exp_addr;
    logic        exp_err;
    bit          rnd_ready;
    int          tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rword(input logic [31:0] rs, rt, rd, sh, fn);
        return (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn;
    endfunction

    function automatic logic [31:0] iword(input logic [31:0] op, rs, rt, imm16);
        return (op << 26) | (rs << 21) | (rt << 16) | (imm16 & 32'hFFFF);
    endfunction

    task automatic mpush(input logic [31:0] w);
        exp_q.push_back({w, exp_addr});
        exp_addr += 32'd4;
    endtask

    // Reference: what a request should produce, from the instruction-set rules.
    task automatic model(input logic [3:0] kind, input logic [31:0] rs, rt, rd, sh, imm, tgt);
        logic [31:0] hi, lo;
        hi = imm >> 16;
        lo = imm & 32'hFFFF;
        case (kind)
            4'd0: mpush(rword(rs, rt, rd, 0, 32'h21));
            4'd1: mpush(rword(rs, rt, rd, 0, 32'h23));
            4'd2: mpush(iword(32'h0D, rs, rt, lo));
            4'd3: mpush(iword(32'h23, rs, rt, lo));
            4'd4: mpush(iword(32'h2B, rs, rt, lo));
            4'd5: mpush(iword(32'h04, rs, rt, lo));
            4'd6: mpush(iword(32'h0F, 0, rt, lo));
            4'd7: mpush((32'd3 << 26) | tgt);
            4'd8: mpush(rword(rs, 0, 0, 0, 32'h08));
            4'd9: mpush(rword(0, rt, rd, sh, 32'h00));
            4'd10: begin
                if (!LI_EN) exp_err = 1'b1;
                else if (hi == 0) mpush(iword(32'h0D, 0, rt, lo));
                else if (lo == 0) mpush(iword(32'h0F, 0, rt, hi));
                else begin
                    mpush(iword(32'h0F, 0, rt, hi));
                    mpush(iword(32'h0D, rt, rt, lo));
                end
            end
            default: exp_err = 1'b1;
        endcase
    endtask

    // Every word leaving the FIFO must match the model queue head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_pop: got %08h@%08h expected nothing", out_instr, out_addr);
            end else begin
                head_e = exp_q.pop_front();
                chk("pop_instr", out_instr, head_e[63:32]);
                chk("pop_addr", out_addr, head_e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        exp_q.delete();
        exp_addr = BASE;
        exp_err  = 1'b0;
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_level", 32'(level), 0);
        chk("rst_err", 32'(err), 0);
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input logic [3:0] kind, input logic [4:0] rs, rt, rd, sh,
                        input logic [31:0] imm, input logic [25:0] tgt);
        int t = 0;
        in_valid = 1'b1; in_kind = kind; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_imm = imm; in_target = tgt;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                tests++; fails++;
                $display("FAIL in_ready_timeout: got 0 expected 1");
                in_valid = 1'b0;
                tick();
                return;
            end
            tick();
        end
        model(kind, 32'(rs), 32'(rt), 32'(rd), 32'(sh), imm, 32'(tgt));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && t < 100) begin tick(); t++; end
        @(negedge clk);
        chk("drain_q_empty", 32'(exp_q.size()), 0);
        chk("drain_out_valid", 32'(out_valid), 0);
        tick();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rnd_ready = 1'b0;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
        in_imm = '0; in_target = '0; exp_addr = BASE; exp_err = 1'b0;

        vecs.push_back('{4'd0,  5'd1,  5'd2, 5'd3, 5'd7, 32'h0,        26'h0,   32'h00221821});
        vecs.push_back('{4'd1,  5'd1,  5'd2, 5'd3, 5'd0, 32'h0,        26'h0,   32'h00221823});
        vecs.push_back('{4'd2,  5'd0,  5'd8, 5'd0, 5'd0, 32'h1234,     26'h0,   32'h34081234});
        vecs.push_back('{4'd3,  5'd29, 5'd8, 5'd0, 5'd0, 32'hFFFF0004, 26'h0,   32'h8FA80004});
        vecs.push_back('{4'd4,  5'd29, 5'd8, 5'd0, 5'd0, 32'h4,        26'h0,   32'hAFA80004});
        vecs.push_back('{4'd5,  5'd1,  5'd2, 5'd0, 5'd0, 32'hFFFF,     26'h0,   32'h1022FFFF});
        vecs.push_back('{4'd6,  5'd7,  5'd9, 5'd0, 5'd0, 32'h1234,     26'h0,   32'h3C091234});
        vecs.push_back('{4'd7,  5'd0,  5'd0, 5'd0, 5'd0, 32'h0,        26'hC00, 32'h0C000C00});
        vecs.push_back('{4'd8,  5'd31, 5'd5, 5'd6, 5'd3, 32'h0,        26'h0,   32'h03E00008});
        vecs.push_back('{4'd9,  5'd9,  5'd5, 5'd4, 5'd2, 32'h0,        26'h0,   32'h00052080});
`ifdef MIPS_ENC_LI_EN
        vecs.push_back('{4'd10, 5'd0,  5'd9, 5'd0, 5'd0, 32'h00005678, 26'h0,   32'h34095678});
        vecs.push_back('{4'd10, 5'd0,  5'd9, 5'd0, 5'd0, 32'hABCD0000, 26'h0,   32'h3C09ABCD});
`endif

        // Each vector is the first word after reset, so it lands at BASE.
        foreach (vecs[i]) begin
            do_reset();
            out_ready = 1'b0;
            send(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, vecs[i].tgt);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp_instr);
            chk($sformatf("vec%0d_addr", i), out_addr, BASE);
            chk($sformatf("vec%0d_level", i), 32'(level), 1);
            tick();
        end

        // ORI then BEQ come out in order.
        do_reset();
        out_ready = 1'b0;
        send(4'd2, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234, 26'h0);
        send(4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 32'hFFFF, 26'h0);
        @(negedge clk);
        chk("order_level", 32'(level), 2);
        chk("order_head0", out_instr, 32'h34081234);
        tick();
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("order_head1", out_instr, 32'h1022FFFF);
        chk("order_addr1", out_addr, 32'h3004);
        tick();
        out_ready = 1'b0;

        // Fill to DEPTH with back-pressure, then drain.
        do_reset();
        repeat (4) send(4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 26'hC00);
        in_valid = 1'b1;
        @(negedge clk);
        chk("full_level", 32'(level), 4);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_head", out_instr, 32'h0C000C00);
        tick(); tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_head_held", out_instr, 32'h0C000C00);
        chk("full_head_addr", out_addr, 32'h3000);
        chk("full_pop_in_ready", 32'(in_ready), 0);
        in_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("drained_level", 32'(level), 0);
        chk("drained_in_ready", 32'(in_ready), 1);
        chk("drained_q", 32'(exp_q.size()), 0);
        tick();
        out_ready = 1'b0;

        // Illegal kind: sticky err, nothing pushed, address unchanged.
        do_reset();
        send(4'd13, 5'd1, 5'd2, 5'd3, 5'd4, 32'h5555, 26'h0);
        @(negedge clk);
        chk("ill_err", 32'(err), 1);
        chk("ill_level", 32'(level), 0);
        chk("ill_out_valid", 32'(out_valid), 0);
        tick();
        send(4'd9, 5'd0, 5'd5, 5'd4, 5'd2, 32'h0, 26'h0);
        @(negedge clk);
        chk("ill_sll_instr", out_instr, 32'h00052080);
        chk("ill_sll_addr", out_addr, 32'h3000);
        chk("ill_err_sticky", 32'(err), 1);
        tick();

`ifdef MIPS_ENC_LI_EN
        // Two-word LI: in_ready drops while the low half is pushed.
        do_reset();
        send(4'd10, 5'd0, 5'd9, 5'd0, 5'd0, 32'h12345678, 26'h0);
        @(negedge clk);
        chk("li_in_ready_lo", 32'(in_ready), 0);
        chk("li_level1", 32'(level), 1);
        chk("li_hi_word", out_instr, 32'h3C091234);
        tick();
        @(negedge clk);
        chk("li_level2", 32'(level), 2);
        chk("li_in_ready_back", 32'(in_ready), 1);
        tick();
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("li_lo_word", out_instr, 32'h35295678);
        chk("li_lo_addr", out_addr, 32'h3004);
        tick();
        out_ready = 1'b0;

        // Reset while the low half is pending.
        do_reset();
        send(4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 26'h1);
        send(4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 26'h2);
        send(4'd10, 5'd0, 5'd9, 5'd0, 5'd0, 32'h12345678, 26'h0);
        do_reset();
        send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0, 26'h0);
        @(negedge clk);
        chk("midli_level", 32'(level), 1);
        chk("midli_instr", out_instr, 32'h00221821);
        chk("midli_addr", out_addr, 32'h3000);
        tick();
`else
        do_reset();
        send(4'd10, 5'd0, 5'd9, 5'd0, 5'd0, 32'h12345678, 26'h0);
        @(negedge clk);
        chk("li_off_err", 32'(err), 1);
        chk("li_off_level", 32'(level), 0);
        tick();
`endif

        // Randomized traffic with random back-pressure.
        do_reset();
        rnd_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [3:0]  k;
            logic [31:0] imm;
            k = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
            imm = $urandom;
            case ($urandom_range(0, 3))
                0: imm[31:16] = '0;
                1: imm[15:0]  = '0;
                default: ;
            endcase
            send(k, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm, 26'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
        @(negedge clk);
        chk("rand_err", 32'(err), 32'(exp_err));
        chk("rand_addr_next", out_addr, exp_addr);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
